riscv_v_arith_alu_sequencer: RTL and testbench
==============================================

# riscv_v_arith_alu_sequencer

Issue-side controller for the vector arithmetic ALU. It accepts one vector arithmetic request at a time and strip-mines it into `nbeats` ALU-width beats. For each beat it reads source operands from the vector register read port, drives the ALU control and source signals, and captures the ALU result and flags. Results go to the writeback port; a completion response carries flags aggregated across all beats. It sits between vector decode/dispatch and the arithmetic ALU, as the driving (system) end of the ALU interface.

## Interface
- ALU_W, 128, ALU datapath width in bits per beat
- MAX_BEATS, 8, maximum beats per request (VLEN/ALU_W)
- IDX_W, $clog2(MAX_BEATS), beat index width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  sequencer idle, can accept
- req_op  in  3  0 ADD, 1 SUB, 2 MAX, 3 MIN, 4 SEQ, 5 SNE, 6 SLT, 7 SGT
- req_signed  in  1  signed compare/max/min
- req_osize  in  2  element size 0:8b 1:16b 2:32b 3:64b
- req_nbeats  in  IDX_W+1  beats to process
- opr_rd_en  out  1  operand read strobe
- opr_rd_idx  out  IDX_W  beat index being read
- opr_srca, opr_srcb  in  ALU_W  operand data, valid exactly one cycle after opr_rd_en
- alu_is_add, alu_is_sub, alu_is_max, alu_is_min  out  1  ALU op selects
- alu_is_set_equal, alu_is_set_nequal, alu_is_set_less, alu_is_set_greater  out  1  ALU compare selects
- alu_is_signed  out  1  signedness
- alu_dst_osize_vector, alu_src_osize_vector  out  4  one-hot of req_osize
- alu_srca, alu_srcb  out  ALU_W  ALU sources
- alu_result  in  ALU_W  ALU result (combinational from ALU inputs)
- alu_zf, alu_of, alu_cf  in  ALU_W/8  per-byte-lane flags
- wb_valid  out  1  writeback beat valid
- wb_idx  out  IDX_W  writeback beat index
- wb_data  out  ALU_W  writeback data
- done_valid  out  1  one-cycle completion pulse
- done_zf, done_of, done_cf  out  1  aggregated flags
- done_err  out  1  request nbeats exceeded MAX_BEATS

## Operation
- States: IDLE, READ, EXEC, RESP. req_ready=1 only in IDLE.
- IDLE: on req_valid, latch op/signed/osize/nbeats. nbeats=0 goes to RESP. Otherwise go to READ with read counter 0.
- nbeats>MAX_BEATS: clamp to MAX_BEATS and latch done_err=1.
- READ/EXEC are pipelined at one beat per cycle:
  - read beat i in cycle c;
  - ALU beat i in cycle c+1: alu_srca/srcb = opr_srca/srcb combinationally, controls held from registers;
  - capture alu_result on the edge ending c+1; wb beat i valid in cycle c+2.
- Exactly one alu_is_* op select high per op. alu_is_signed=req_signed for all ops. All selects are 0 outside active ALU beats.
- Flag accumulation, initialised at accept: zf_acc=1, of_acc=0, cf_acc=0. Per beat: zf_acc &= &alu_zf; of_acc |= |alu_of; cf_acc |= |alu_cf.
- RESP: done_valid=1 for one cycle, done flags = accumulators, then IDLE.
- The last writeback beat and done_valid occur in the same cycle.
- nbeats=0: no reads, no wb. done_zf=1, done_of=0, done_cf=0.
- Back-to-back requests are not overlapped. A new request is accepted the cycle after done_valid.

## Timing
- Accept edge = cycle 0. opr_rd_en high cycles 1..N with idx 0..N-1.
- ALU driven in cycles 2..N+1. wb_valid in cycles 3..N+2. done_valid in cycle N+2. req_ready high again in cycle N+3.
- nbeats=0: done_valid in cycle 1, req_ready in cycle 2.
- Reset values: req_ready=1; every other output 0 (all alu_*, wb_*, done_*, opr_*).
- Asserting rst_n low mid-request aborts it immediately: outputs go to reset values and no done_valid is produced. After release, the block is IDLE.
- No backpressure on wb or done. Consumers must sample on the valid cycle.

## Test plan
- ADD, osize=2, nbeats=4, srca beat i = i+1 per lane, srcb=1 -> wb_idx 0..3 in cycles 3..6; wb_data lanes = i+2; done_valid cycle 6; done_zf=0.
- SUB, nbeats=2, srca=srcb -> alu_zf all ones; done_zf=1, done_of=0, done_cf=0.
- SLT signed, osize=0, srca=0x80 lanes, srcb=0x01 -> alu_is_set_less=1, alu_is_signed=1, alu_dst_osize_vector=4'b0001, one-hot held across all beats.
- nbeats=0 -> no opr_rd_en, no wb_valid; done_valid cycle 1 with zf=1. nbeats=15 with MAX_BEATS=8 -> 8 beats, done_err=1.
- Drop rst_n in cycle 3 of a 6-beat request -> all outputs 0 and req_ready=1 asynchronously. No done_valid. A new ADD request accepted after release completes normally.
- Two requests presented back-to-back -> second accepted only in cycle N+3 of the first; the first request's flags do not leak into the second.

Source files
------------

// File: rtl/riscv_v_arith_alu_sequencer_if.sv
// Bundle between vector dispatch, operand read port, arithmetic ALU, writeback and
// completion. 'master' is the sequencer's view, 'slave' is everything around it.
interface riscv_v_arith_alu_sequencer_if #(
    parameter int ALU_W     = 128,
    parameter int MAX_BEATS = 8,
    parameter int IDX_W     = $clog2(MAX_BEATS)
);
    localparam int LANES = ALU_W / 8;

    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic             req_signed;
    logic [1:0]       req_osize;
    logic [IDX_W:0]   req_nbeats;

    logic             opr_rd_en;
    logic [IDX_W-1:0] opr_rd_idx;
    logic [ALU_W-1:0] opr_srca;
    logic [ALU_W-1:0] opr_srcb;

    logic             alu_is_add;
    logic             alu_is_sub;
    logic             alu_is_max;
    logic             alu_is_min;
    logic             alu_is_set_equal;
    logic             alu_is_set_nequal;
    logic             alu_is_set_less;
    logic             alu_is_set_greater;
    logic             alu_is_signed;
    logic [3:0]       alu_dst_osize_vector;
    logic [3:0]       alu_src_osize_vector;
    logic [ALU_W-1:0] alu_srca;
    logic [ALU_W-1:0] alu_srcb;
    logic [ALU_W-1:0] alu_result;
    logic [LANES-1:0] alu_zf;
    logic [LANES-1:0] alu_of;
    logic [LANES-1:0] alu_cf;

    logic             wb_valid;
    logic [IDX_W-1:0] wb_idx;
    logic [ALU_W-1:0] wb_data;

    logic             done_valid;
    logic             done_zf;
    logic             done_of;
    logic             done_cf;
    logic             done_err;

    modport master (
        input  req_valid, req_op, req_signed, req_osize, req_nbeats,
        input  opr_srca, opr_srcb,
        input  alu_result, alu_zf, alu_of, alu_cf,
        output req_ready,
        output opr_rd_en, opr_rd_idx,
        output alu_is_add, alu_is_sub, alu_is_max, alu_is_min,
        output alu_is_set_equal, alu_is_set_nequal, alu_is_set_less, alu_is_set_greater,
        output alu_is_signed, alu_dst_osize_vector, alu_src_osize_vector,
        output alu_srca, alu_srcb,
        output wb_valid, wb_idx, wb_data,
        output done_valid, done_zf, done_of, done_cf, done_err
    );

    modport slave (
        output req_valid, req_op, req_signed, req_osize, req_nbeats,
        output opr_srca, opr_srcb,
        output alu_result, alu_zf, alu_of, alu_cf,
        input  req_ready,
        input  opr_rd_en, opr_rd_idx,
        input  alu_is_add, alu_is_sub, alu_is_max, alu_is_min,
        input  alu_is_set_equal, alu_is_set_nequal, alu_is_set_less, alu_is_set_greater,
        input  alu_is_signed, alu_dst_osize_vector, alu_src_osize_vector,
        input  alu_srca, alu_srcb,
        input  wb_valid, wb_idx, wb_data,
        input  done_valid, done_zf, done_of, done_cf, done_err
    );
endinterface

// File: rtl/riscv_v_arith_alu_sequencer.sv
// Strip-mines one vector arithmetic request into ALU-width beats: read, execute and
// writeback overlap at one beat per cycle; flags are folded into a single completion.
module riscv_v_arith_alu_sequencer #(
    parameter int ALU_W     = 128,
    parameter int MAX_BEATS = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    riscv_v_arith_alu_sequencer_if.master bus
);
    localparam int             IDX_W  = $clog2(MAX_BEATS);
    localparam logic [IDX_W:0] MAX_NB = (IDX_W+1)'(MAX_BEATS);
    localparam logic [IDX_W:0] ONE_NB = (IDX_W+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_RESP
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MAX = 3'd2,
        OP_MIN = 3'd3,
        OP_SEQ = 3'd4,
        OP_SNE = 3'd5,
        OP_SLT = 3'd6,
        OP_SGT = 3'd7
    } op_t;

    state_t           r_state;
    state_t           w_next;
    logic             w_accept;
    logic             w_rd_en;
    logic             w_done;
    logic             w_ready;
    logic             w_last_rd;
    logic [IDX_W:0]   w_nb_clamped;
    logic [3:0]       w_osize_oh;

    op_t              r_op;
    logic             r_signed;
    logic [1:0]       r_osize;
    logic [IDX_W:0]   r_nbeats;
    logic             r_err;
    logic [IDX_W-1:0] r_rd_cnt;
    logic             r_alu_vld;
    logic [IDX_W-1:0] r_alu_idx;
    logic             r_wb_valid;
    logic [IDX_W-1:0] r_wb_idx;
    logic [ALU_W-1:0] r_wb_data;
    logic             r_zf_acc;
    logic             r_of_acc;
    logic             r_cf_acc;

    assign w_last_rd    = ({1'b0, r_rd_cnt} == (r_nbeats - ONE_NB));
    assign w_nb_clamped = (bus.req_nbeats > MAX_NB) ? MAX_NB : bus.req_nbeats;
    assign w_osize_oh   = 4'b0001 << r_osize;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_rd_en  = 1'b0;
        w_done   = 1'b0;
        w_ready  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (bus.req_valid) begin
                    w_accept = 1'b1;
                    w_next   = (bus.req_nbeats == '0) ? S_RESP : S_READ;
                end
            end
            S_READ: begin
                w_rd_en = 1'b1;
                if (w_last_rd) begin
                    w_next = S_EXEC;
                end
            end
            // Drains the final ALU beat; its result is captured on the edge leaving EXEC.
            S_EXEC: begin
                w_next = S_RESP;
            end
            S_RESP: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op       <= OP_ADD;
            r_signed   <= 1'b0;
            r_osize    <= '0;
            r_nbeats   <= '0;
            r_err      <= 1'b0;
            r_rd_cnt   <= '0;
            r_alu_vld  <= 1'b0;
            r_alu_idx  <= '0;
            r_wb_valid <= 1'b0;
            r_wb_idx   <= '0;
            r_wb_data  <= '0;
            r_zf_acc   <= 1'b0;
            r_of_acc   <= 1'b0;
            r_cf_acc   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op     <= op_t'(bus.req_op);
                r_signed <= bus.req_signed;
                r_osize  <= bus.req_osize;
                r_nbeats <= w_nb_clamped;
                r_err    <= (bus.req_nbeats > MAX_NB);
                r_rd_cnt <= '0;
            end else if (w_rd_en) begin
                r_rd_cnt <= r_rd_cnt + 1'b1;
            end

            r_alu_vld  <= w_rd_en;
            r_alu_idx  <= w_rd_en ? r_rd_cnt : '0;
            r_wb_valid <= r_alu_vld;
            r_wb_idx   <= r_alu_vld ? r_alu_idx : '0;
            r_wb_data  <= r_alu_vld ? bus.alu_result : '0;

            // Accept never coincides with an ALU beat, so the two updates cannot collide.
            if (w_accept) begin
                r_zf_acc <= 1'b1;
                r_of_acc <= 1'b0;
                r_cf_acc <= 1'b0;
            end else if (r_alu_vld) begin
                r_zf_acc <= r_zf_acc & (&bus.alu_zf);
                r_of_acc <= r_of_acc | (|bus.alu_of);
                r_cf_acc <= r_cf_acc | (|bus.alu_cf);
            end
        end
    end

    assign bus.req_ready  = w_ready;
    assign bus.opr_rd_en  = w_rd_en;
    assign bus.opr_rd_idx = w_rd_en ? r_rd_cnt : '0;

    assign bus.alu_is_add         = r_alu_vld && (r_op == OP_ADD);
    assign bus.alu_is_sub         = r_alu_vld && (r_op == OP_SUB);
    assign bus.alu_is_max         = r_alu_vld && (r_op == OP_MAX);
    assign bus.alu_is_min         = r_alu_vld && (r_op == OP_MIN);
    assign bus.alu_is_set_equal   = r_alu_vld && (r_op == OP_SEQ);
    assign bus.alu_is_set_nequal  = r_alu_vld && (r_op == OP_SNE);
    assign bus.alu_is_set_less    = r_alu_vld && (r_op == OP_SLT);
    assign bus.alu_is_set_greater = r_alu_vld && (r_op == OP_SGT);
    assign bus.alu_is_signed      = r_alu_vld && r_signed;

    assign bus.alu_dst_osize_vector = r_alu_vld ? w_osize_oh : '0;
    assign bus.alu_src_osize_vector = r_alu_vld ? w_osize_oh : '0;
    assign bus.alu_srca             = r_alu_vld ? bus.opr_srca : '0;
    assign bus.alu_srcb             = r_alu_vld ? bus.opr_srcb : '0;

    assign bus.wb_valid = r_wb_valid;
    assign bus.wb_idx   = r_wb_idx;
    assign bus.wb_data  = r_wb_data;

    assign bus.done_valid = w_done;
    assign bus.done_zf    = w_done && r_zf_acc;
    assign bus.done_of    = w_done && r_of_acc;
    assign bus.done_cf    = w_done && r_cf_acc;
    assign bus.done_err   = w_done && r_err;
endmodule

// File: tb/tb_riscv_v_arith_alu_sequencer.sv
// Bench for the vector ALU sequencer: acts as dispatch, operand file and a lane-wise ALU,
// and checks every cycle of each request against timing and results derived from the rules.
module tb_riscv_v_arith_alu_sequencer;
    localparam int W  = 128;
    localparam int MB = 8;
    localparam int IW = 3;
    localparam int L  = W / 8;

    typedef struct {
        logic [2:0] op;
        logic       sgn;
        logic [1:0] os;
        logic [3:0] nb;
        int         pat;
        logic       e_err;
        logic       e_zf;
        logic       e_of;
        logic       e_cf;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    riscv_v_arith_alu_sequencer_if #(.ALU_W(W), .MAX_BEATS(MB)) bus_if ();

    riscv_v_arith_alu_sequencer #(.ALU_W(W), .MAX_BEATS(MB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [W-1:0] mem_a [MB];
    logic [W-1:0] mem_b [MB];
    vec_t tbl [9];

    // Lane-wise ALU: element width from osize, flags replicated over each element's bytes.
    function automatic void alu_fn(input logic [2:0] op, input logic sgn, input logic [1:0] os,
                                   input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] r, output logic [L-1:0] zf,
                                   output logic [L-1:0] of, output logic [L-1:0] cf);
        int unsigned ew, nbytes;
        logic [63:0] ea, eb, er, mask;
        logic signed [64:0] sa, sb;
        logic [64:0] s;
        logic c, o, lt, gt, as_, bs_;
        ew = 8 << os;
        nbytes = ew / 8;
        mask = (ew == 64) ? '1 : ((64'd1 << ew) - 64'd1);
        r = '0; zf = '0; of = '0; cf = '0;
        for (int unsigned e = 0; e < W / ew; e++) begin
            ea = 64'(a >> (e * ew)) & mask;
            eb = 64'(b >> (e * ew)) & mask;
            as_ = ea[ew-1];
            bs_ = eb[ew-1];
            sa = (sgn && as_) ? {1'b1, ea | ~mask} : {1'b0, ea};
            sb = (sgn && bs_) ? {1'b1, eb | ~mask} : {1'b0, eb};
            lt = sa < sb;
            gt = sb < sa;
            c = 1'b0; o = 1'b0; s = '0;
            case (op)
                3'd0: begin
                    s = {1'b0, ea} + {1'b0, eb};
                    er = s[63:0] & mask;
                    c = s[ew];
                    o = (as_ == bs_) && (er[ew-1] != as_);
                end
                3'd1: begin
                    s = {1'b0, ea} - {1'b0, eb};
                    er = s[63:0] & mask;
                    c = ea < eb;
                    o = (as_ != bs_) && (er[ew-1] != as_);
                end
                3'd2:    er = lt ? eb : ea;
                3'd3:    er = lt ? ea : eb;
                3'd4:    er = {63'd0, ea == eb};
                3'd5:    er = {63'd0, ea != eb};
                3'd6:    er = {63'd0, lt};
                default: er = {63'd0, gt};
            endcase
            r = r | (W'(er) << (e * ew));
            for (int unsigned k = 0; k < nbytes; k++) begin
                cf[e * nbytes + k] = c;
                of[e * nbytes + k] = o;
            end
        end
        for (int unsigned j = 0; j < L; j++) zf[j] = (r[j*8 +: 8] == 8'd0);
    endfunction

    logic [2:0]   m_op;
    logic [1:0]   m_os;
    logic         m_any;
    logic [W-1:0] m_r;
    logic [L-1:0] m_z, m_o, m_c;
    always_comb begin
        m_r = '0; m_z = '0; m_o = '0; m_c = '0;
        m_any = bus_if.alu_is_add | bus_if.alu_is_sub | bus_if.alu_is_max | bus_if.alu_is_min |
                bus_if.alu_is_set_equal | bus_if.alu_is_set_nequal | bus_if.alu_is_set_less |
                bus_if.alu_is_set_greater;
        m_op = bus_if.alu_is_add ? 3'd0 : bus_if.alu_is_sub ? 3'd1 : bus_if.alu_is_max ? 3'd2 :
               bus_if.alu_is_min ? 3'd3 : bus_if.alu_is_set_equal ? 3'd4 :
               bus_if.alu_is_set_nequal ? 3'd5 : bus_if.alu_is_set_less ? 3'd6 : 3'd7;
        m_os = bus_if.alu_dst_osize_vector[0] ? 2'd0 : bus_if.alu_dst_osize_vector[1] ? 2'd1 :
               bus_if.alu_dst_osize_vector[2] ? 2'd2 : 2'd3;
        alu_fn(m_op, bus_if.alu_is_signed, m_os, bus_if.alu_srca, bus_if.alu_srcb, m_r, m_z, m_o, m_c);
        bus_if.alu_result = m_any ? m_r : '0;
        bus_if.alu_zf     = m_any ? m_z : '0;
        bus_if.alu_of     = m_any ? m_o : '0;
        bus_if.alu_cf     = m_any ? m_c : '0;
    end

    // Operand file: data for a read strobed in cycle c is presented throughout cycle c+1.
    initial begin
        logic          en;
        logic [IW-1:0] idx;
        bus_if.opr_srca = '0;
        bus_if.opr_srcb = '0;
        forever begin
            @(negedge clk);
            en  = bus_if.opr_rd_en;
            idx = bus_if.opr_rd_idx;
            @(posedge clk);
            #1;
            bus_if.opr_srca = en ? mem_a[idx] : '0;
            bus_if.opr_srcb = en ? mem_b[idx] : '0;
        end
    end

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] selvec();
        return {bus_if.alu_is_add, bus_if.alu_is_sub, bus_if.alu_is_max, bus_if.alu_is_min,
                bus_if.alu_is_set_equal, bus_if.alu_is_set_nequal, bus_if.alu_is_set_less,
                bus_if.alu_is_set_greater};
    endfunction

    function automatic logic [W-1:0] rep(input logic [1:0] os, input logic [63:0] v);
        int unsigned ew;
        logic [63:0] mask;
        logic [W-1:0] r;
        ew = 8 << os;
        mask = (ew == 64) ? '1 : ((64'd1 << ew) - 64'd1);
        r = '0;
        for (int unsigned e = 0; e < W / ew; e++) r = r | (W'(v & mask) << (e * ew));
        return r;
    endfunction

    task automatic fill_mem(input int pat, input logic [1:0] os);
        for (int i = 0; i < MB; i++) begin
            case (pat)
                0: begin mem_a[i] = rep(os, 64'(i + 1)); mem_b[i] = rep(os, 64'd1); end
                1: begin mem_a[i] = {4{32'hA5C3_1E69}}; mem_b[i] = {4{32'hA5C3_1E69}}; end
                2: begin mem_a[i] = rep(2'd0, 64'h80); mem_b[i] = rep(2'd0, 64'h01); end
                3: begin mem_a[i] = rep(2'd0, 64'hFF); mem_b[i] = rep(2'd0, 64'h01); end
                4: begin mem_a[i] = rep(2'd0, 64'h7F); mem_b[i] = rep(2'd0, 64'h01); end
                default: begin
                    mem_a[i] = {$urandom, $urandom, $urandom, $urandom};
                    mem_b[i] = {$urandom, $urandom, $urandom, $urandom};
                end
            endcase
        end
    endtask

    task automatic model_flags(inout vec_t v);
        logic [W-1:0] r;
        logic [L-1:0] z, o, c;
        int neff;
        neff = (v.nb > 4'(MB)) ? MB : int'(v.nb);
        v.e_err = v.nb > 4'(MB);
        v.e_zf = 1'b1; v.e_of = 1'b0; v.e_cf = 1'b0;
        for (int i = 0; i < neff; i++) begin
            alu_fn(v.op, v.sgn, v.os, mem_a[i], mem_b[i], r, z, o, c);
            v.e_zf = v.e_zf & (&z);
            v.e_of = v.e_of | (|o);
            v.e_cf = v.e_cf | (|c);
        end
    endtask

    task automatic start_req(input vec_t v, output int waited, output bit ok);
        bus_if.req_op     = v.op;
        bus_if.req_signed = v.sgn;
        bus_if.req_osize  = v.os;
        bus_if.req_nbeats = v.nb;
        bus_if.req_valid  = 1'b1;
        waited = 0;
        while (!bus_if.req_ready && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        ok = bus_if.req_ready;
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: got req_ready=0 for %0d cycles, expected 1", waited);
            bus_if.req_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_req(input vec_t v, input bit hold, input vec_t nxt, input bit expect_now);
        logic [W-1:0] ed [MB];
        logic [W-1:0] r;
        logic [L-1:0] z, o, c;
        int neff, done_c, waited;
        bit ok, rd_exp, alu_exp, wb_exp;
        neff = (v.nb > 4'(MB)) ? MB : int'(v.nb);
        for (int i = 0; i < neff; i++) begin
            alu_fn(v.op, v.sgn, v.os, mem_a[i], mem_b[i], r, z, o, c);
            ed[i] = r;
        end
        start_req(v, waited, ok);
        if (!ok) return;
        if (expect_now) chk("b2b_accept_wait", W'(waited), W'(0));
        if (hold) begin
            bus_if.req_op     = nxt.op;
            bus_if.req_signed = nxt.sgn;
            bus_if.req_osize  = nxt.os;
            bus_if.req_nbeats = nxt.nb;
        end else begin
            bus_if.req_valid = 1'b0;
        end
        done_c = (neff == 0) ? 1 : neff + 2;
        for (int cyc = 1; cyc <= done_c + 1; cyc++) begin
            @(negedge clk);
            rd_exp  = (cyc <= neff);
            alu_exp = (cyc >= 2) && (cyc <= neff + 1);
            wb_exp  = (cyc >= 3) && (cyc <= neff + 2);
            chk("opr_rd_en", W'(bus_if.opr_rd_en), W'(rd_exp));
            if (rd_exp) chk("opr_rd_idx", W'(bus_if.opr_rd_idx), W'(cyc - 1));
            chk("alu_sel", W'(selvec()), alu_exp ? W'(8'h80 >> v.op) : W'(0));
            if (alu_exp) begin
                chk("alu_signed", W'(bus_if.alu_is_signed), W'(v.sgn));
                chk("alu_osize", W'({bus_if.alu_dst_osize_vector, bus_if.alu_src_osize_vector}),
                    W'({2{4'b0001 << v.os}}));
                chk("alu_srca", bus_if.alu_srca, mem_a[cyc - 2]);
                chk("alu_srcb", bus_if.alu_srcb, mem_b[cyc - 2]);
            end
            chk("wb_valid", W'(bus_if.wb_valid), W'(wb_exp));
            if (wb_exp) begin
                chk("wb_idx", W'(bus_if.wb_idx), W'(cyc - 3));
                chk("wb_data", bus_if.wb_data, ed[cyc - 3]);
            end
            chk("done_valid", W'(bus_if.done_valid), W'(cyc == done_c));
            if (cyc == done_c)
                chk("done_err_zf_of_cf", W'({bus_if.done_err, bus_if.done_zf, bus_if.done_of, bus_if.done_cf}),
                    W'({v.e_err, v.e_zf, v.e_of, v.e_cf}));
            chk("req_ready", W'(bus_if.req_ready), W'(cyc == done_c + 1));
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_req_ready"}, W'(bus_if.req_ready), W'(1));
        chk({tag, "_opr"}, W'({bus_if.opr_rd_en, bus_if.opr_rd_idx}), W'(0));
        chk({tag, "_alu_ctl"}, W'({selvec(), bus_if.alu_is_signed, bus_if.alu_dst_osize_vector,
                                   bus_if.alu_src_osize_vector}), W'(0));
        chk({tag, "_alu_srca"}, bus_if.alu_srca, W'(0));
        chk({tag, "_wb"}, W'({bus_if.wb_valid, bus_if.wb_idx}), W'(0));
        chk({tag, "_wb_data"}, bus_if.wb_data, W'(0));
        chk({tag, "_done"}, W'({bus_if.done_valid, bus_if.done_zf, bus_if.done_of, bus_if.done_cf,
                                bus_if.done_err}), W'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected bench to finish");
        $fatal(1);
    end

    initial begin
        vec_t v, v2;
        int   waited;
        bit   ok;
        //            op    sgn   os    nb     pat err   zf    of    cf
        tbl[0] = '{3'd0, 1'b0, 2'd2, 4'd4,  0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{3'd1, 1'b0, 2'd2, 4'd2,  1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{3'd6, 1'b1, 2'd0, 4'd3,  2, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{3'd0, 1'b0, 2'd2, 4'd0,  0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{3'd0, 1'b0, 2'd2, 4'd15, 0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{3'd0, 1'b0, 2'd0, 4'd2,  3, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[6] = '{3'd0, 1'b1, 2'd0, 4'd1,  4, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[7] = '{3'd2, 1'b0, 2'd3, 4'd8,  1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{3'd5, 1'b0, 2'd1, 4'd3,  1, 1'b0, 1'b1, 1'b0, 1'b0};

        bus_if.req_valid = 1'b0; bus_if.req_op = '0; bus_if.req_signed = 1'b0;
        bus_if.req_osize = '0;   bus_if.req_nbeats = '0;
        fill_mem(0, 2'd2);
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            fill_mem(tbl[i].pat, tbl[i].os);
            run_req(tbl[i], 1'b0, tbl[i], 1'b0);
        end

        // Back-to-back: second request waits while busy and must not inherit zf/cf.
        v  = tbl[5];
        v2 = tbl[0];
        v2.nb = 4'd3;
        fill_mem(v.pat, v.os);
        run_req(v, 1'b1, v2, 1'b0);
        fill_mem(v2.pat, v2.os);
        run_req(v2, 1'b0, v2, 1'b1);

        // Reset in cycle 3 of a 6-beat request.
        v = tbl[0];
        v.nb = 4'd6;
        fill_mem(0, 2'd2);
        start_req(v, waited, ok);
        bus_if.req_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_idle_outputs("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("post_reset_quiet", W'({bus_if.done_valid, bus_if.wb_valid, bus_if.opr_rd_en}), W'(0));
        end
        fill_mem(0, 2'd2);
        run_req(tbl[0], 1'b0, tbl[0], 1'b0);

        for (int n = 0; n < 30; n++) begin
            v.op  = 3'($urandom_range(0, 7));
            v.sgn = 1'($urandom_range(0, 1));
            v.os  = 2'($urandom_range(0, 3));
            v.nb  = 4'($urandom_range(0, 10));
            v.pat = 5;
            fill_mem(v.pat, v.os);
            model_flags(v);
            run_req(v, 1'b0, v, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
